// File: rtl/apb_bridge_arb.sv
// Two-master AHB-Lite arbiter in front of the AHB-to-APB bridge slave port.
// Define APB_ARB_RR_EN for round-robin arbitration; the default is fixed priority with m0 first.
module apb_bridge_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_hsel,
  input  logic [ADDR_W-1:0] m0_haddr,
  input  logic [1:0]        m0_htrans,
  input  logic              m0_hwrite,
  input  logic [2:0]        m0_hsize,
  input  logic [DATA_W-1:0] m0_hwdata,
  output logic              m0_hready,
  output logic [DATA_W-1:0] m0_hrdata,
  output logic              m0_hresp,
  input  logic              m1_hsel,
  input  logic [ADDR_W-1:0] m1_haddr,
  input  logic [1:0]        m1_htrans,
  input  logic              m1_hwrite,
  input  logic [2:0]        m1_hsize,
  input  logic [DATA_W-1:0] m1_hwdata,
  output logic              m1_hready,
  output logic [DATA_W-1:0] m1_hrdata,
  output logic              m1_hresp,
  output logic              s_hsel,
  output logic [ADDR_W-1:0] s_haddr,
  output logic [1:0]        s_htrans,
  output logic              s_hwrite,
  output logic [2:0]        s_hsize,
  output logic [2:0]        s_hburst,
  output logic [3:0]        s_hprot,
  output logic [DATA_W-1:0] s_hwdata,
  output logic              s_hready_in,
  input  logic [DATA_W-1:0] s_hrdata,
  input  logic              s_hready_out,
  input  logic              s_hresp
);

  typedef enum logic [1:0] {HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11} htrans_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [2:0]        size;
  } ctrl_t;

  logic [1:0] pend;
  logic [1:0] live;
  logic [1:0] req;
  logic [1:0] win;
  logic       dp_valid;
  logic       dp_owner;
  logic       last_grant;
  logic       grant_any;
  logic       grant1;
  ctrl_t      live_ctrl [2];
  ctrl_t      hold      [2];
  ctrl_t      cand      [2];
  ctrl_t      win_ctrl;

  // A data-phase owner sees the bridge ready; a master with a captured request waits.
  assign m0_hready = (dp_valid && !dp_owner) ? s_hready_out : !pend[0];
  assign m1_hready = (dp_valid &&  dp_owner) ? s_hready_out : !pend[1];

  assign live[0] = m0_hsel & m0_htrans[1] & m0_hready;
  assign live[1] = m1_hsel & m1_htrans[1] & m1_hready;
  assign req     = pend | live;

  assign live_ctrl[0] = '{addr: m0_haddr, write: m0_hwrite, size: m0_hsize};
  assign live_ctrl[1] = '{addr: m1_haddr, write: m1_hwrite, size: m1_hsize};
  assign cand[0]      = pend[0] ? hold[0] : live_ctrl[0];
  assign cand[1]      = pend[1] ? hold[1] : live_ctrl[1];

  // Gating with rst_n keeps the bridge idle while reset is held, whatever the masters drive.
  assign grant_any = s_hready_out & rst_n & (|req);
`ifdef APB_ARB_RR_EN
  assign grant1 = req[1] & (!req[0] | !last_grant);
`else
  assign grant1 = req[1] & !req[0];
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif
  assign win      = grant_any ? {grant1, !grant1} : 2'b00;
  assign win_ctrl = grant1 ? cand[1] : cand[0];

  // NOTE: every output below has an explicit value on the no-grant path, so no latch can form.
  always_comb begin
    s_hsel   = 1'b0;
    s_htrans = HT_IDLE;
    s_haddr  = '0;
    s_hwrite = 1'b0;
    s_hsize  = 3'b000;
    if (grant_any) begin
      s_hsel   = 1'b1;
      s_htrans = HT_NONSEQ;
      s_haddr  = win_ctrl.addr;
      s_hwrite = win_ctrl.write;
      s_hsize  = win_ctrl.size;
    end
  end

  assign s_hburst    = 3'b000;
  assign s_hprot     = 4'b0011;
  assign s_hready_in = s_hready_out;
  assign s_hwdata    = !dp_valid ? '0 : (dp_owner ? m1_hwdata : m0_hwdata);
  assign m0_hrdata   = s_hrdata;
  assign m1_hrdata   = s_hrdata;
  assign m0_hresp    = dp_valid & !dp_owner & s_hresp;
  assign m1_hresp    = dp_valid &  dp_owner & s_hresp;

  // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= 2'b00;
      dp_valid   <= 1'b0;
      dp_owner   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (s_hready_out) begin
        dp_valid <= grant_any;
        if (grant_any) begin
          dp_owner   <= grant1;
          last_grant <= grant1;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (win[i])       pend[i] <= 1'b0;
        else if (live[i]) pend[i] <= 1'b1;
      end
    end
  end

  // NOTE: holding registers carry no reset; their contents are only used while pend is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!win[i] && live[i]) hold[i] <= live_ctrl[i];
    end
  end

  logic unused_htrans;
  assign unused_htrans = m0_htrans[0] ^ m1_htrans[0];

endmodule

// File: tb/tb_apb_bridge_arb.sv
// Self-checking bench for apb_bridge_arb: vector table with scoreboard queue, plus reset and contention sequences.
// Expectations follow APB_ARB_RR_EN when it is defined for the build.
module tb_apb_bridge_arb;

  localparam logic [31:0] D0 = 32'hA0A0_0A00;
  localparam logic [31:0] D1 = 32'hB1B1_0B11;
  localparam logic [31:0] RD = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_hsel, m1_hsel, m0_hwrite, m1_hwrite;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
  logic [1:0]  m0_htrans, m1_htrans;
  logic [2:0]  m0_hsize, m1_hsize;
  logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic        s_hsel, s_hwrite, s_hready_in, s_hready_out, s_hresp;
  logic [31:0] s_haddr, s_hwdata, s_hrdata;
  logic [1:0]  s_htrans;
  logic [2:0]  s_hsize, s_hburst;
  logic [3:0]  s_hprot;

  apb_bridge_arb #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_hsel(m0_hsel), .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite),
    .m0_hsize(m0_hsize), .m0_hwdata(m0_hwdata), .m0_hready(m0_hready), .m0_hrdata(m0_hrdata),
    .m0_hresp(m0_hresp),
    .m1_hsel(m1_hsel), .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite),
    .m1_hsize(m1_hsize), .m1_hwdata(m1_hwdata), .m1_hready(m1_hready), .m1_hrdata(m1_hrdata),
    .m1_hresp(m1_hresp),
    .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
    .s_hsize(s_hsize), .s_hburst(s_hburst), .s_hprot(s_hprot), .s_hwdata(s_hwdata),
    .s_hready_in(s_hready_in), .s_hrdata(s_hrdata), .s_hready_out(s_hready_out), .s_hresp(s_hresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  t0;
    logic [31:0] a0;
    logic        w0;
    logic [1:0]  t1;
    logic [31:0] a1;
    logic        w1;
    logic        rdy;
    logic        resp;
    logic        e_sel;
    logic [31:0] e_addr;
    logic        e_w;
    logic        e_h0;
    logic        e_h1;
    int          e_ws;   // 0: zero, 1: m0 data, 2: m1 data
    logic        e_r0;
    logic        e_r1;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
  } grant_t;

  vec_t   vecs [14];
  vec_t   exp_q [$];
  grant_t grant_q [$];
  int     n_checks = 0;
  int     n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input string name, input logic [1:0] t0, input logic [31:0] a0,
                              input logic w0, input logic [1:0] t1, input logic [31:0] a1,
                              input logic w1, input logic rdy, input logic resp, input logic e_sel,
                              input logic [31:0] e_addr, input logic e_w, input logic e_h0,
                              input logic e_h1, input int e_ws, input logic e_r0, input logic e_r1);
    vec_t v;
    v.name = name; v.t0 = t0; v.a0 = a0; v.w0 = w0; v.t1 = t1; v.a1 = a1; v.w1 = w1;
    v.rdy = rdy; v.resp = resp; v.e_sel = e_sel; v.e_addr = e_addr; v.e_w = e_w;
    v.e_h0 = e_h0; v.e_h1 = e_h1; v.e_ws = e_ws; v.e_r0 = e_r0; v.e_r1 = e_r1;
    return v;
  endfunction

  task automatic drive_idle(input logic rdy);
    m0_hsel = 0; m0_htrans = 2'b00; m0_haddr = '0; m0_hwrite = 0; m0_hsize = 3'b010; m0_hwdata = D0;
    m1_hsel = 0; m1_htrans = 2'b00; m1_haddr = '0; m1_hwrite = 0; m1_hsize = 3'b001; m1_hwdata = D1;
    s_hready_out = rdy; s_hresp = 0; s_hrdata = RD;
  endtask

  task automatic drive_vec(input vec_t v, input int i);
    m0_hsel = (v.t0 != 2'b00); m0_htrans = v.t0; m0_haddr = v.a0; m0_hwrite = v.w0;
    m1_hsel = (v.t1 != 2'b00); m1_htrans = v.t1; m1_haddr = v.a1; m1_hwrite = v.w1;
    s_hready_out = v.rdy; s_hresp = v.resp; s_hrdata = RD ^ i;
  endtask

  initial begin
    logic [31:0] exp_wd;
    vec_t        e;
    int          idx0, idx1;
    logic        acc0, acc1;

    vecs[0]  = mk("reset_idle", 2'b00, 32'h0, 0, 2'b00, 32'h0, 0, 1, 0,  0, 32'h0, 0, 1, 1, 0, 0, 0);
    vecs[1]  = mk("m0_read", 2'b10, 32'h4000_0104, 0, 2'b00, 32'h0, 0, 1, 0,  1, 32'h4000_0104, 0, 1, 1, 0, 0, 0);
    vecs[2]  = mk("m0_stall", 2'b00, 32'h0, 0, 2'b00, 32'h0, 0, 0, 0,  0, 32'h0, 0, 0, 1, 1, 0, 0);
    vecs[3]  = mk("m1_capture", 2'b00, 32'h0, 0, 2'b10, 32'h4000_0300, 1, 0, 0,  0, 32'h0, 0, 0, 1, 1, 0, 0);
    vecs[4]  = mk("m1_held", 2'b00, 32'h0, 0, 2'b10, 32'h4000_0300, 1, 0, 1,  0, 32'h0, 0, 0, 0, 1, 1, 0);
    vecs[5]  = mk("m1_issue", 2'b00, 32'h0, 0, 2'b10, 32'h4000_0300, 1, 1, 0,  1, 32'h4000_0300, 1, 1, 0, 1, 0, 0);
    vecs[6]  = mk("m1_data", 2'b00, 32'h0, 0, 2'b00, 32'h0, 0, 1, 0,  0, 32'h0, 0, 1, 1, 2, 0, 0);
    vecs[7]  = mk("both_write", 2'b10, 32'h4000_0200, 1, 2'b10, 32'h4000_0300, 1, 1, 0,  1, 32'h4000_0200, 1, 1, 1, 0, 0, 0);
    vecs[8]  = mk("m1_pending", 2'b00, 32'h0, 0, 2'b10, 32'h4000_0300, 1, 1, 0,  1, 32'h4000_0300, 1, 1, 0, 1, 0, 0);
    vecs[9]  = mk("m1_wdata", 2'b00, 32'h0, 0, 2'b00, 32'h0, 0, 1, 0,  0, 32'h0, 0, 1, 1, 2, 0, 0);
    vecs[10] = mk("m0_seq", 2'b11, 32'h4000_0108, 0, 2'b00, 32'h0, 0, 1, 0,  1, 32'h4000_0108, 0, 1, 1, 0, 0, 0);
`ifdef APB_ARB_RR_EN
    vecs[11] = mk("contend_rr", 2'b10, 32'h4000_0400, 1, 2'b10, 32'h4000_0500, 1, 1, 0,  1, 32'h4000_0500, 1, 1, 1, 1, 0, 0);
    vecs[12] = mk("loser_rr", 2'b00, 32'h0, 0, 2'b00, 32'h0, 0, 1, 0,  1, 32'h4000_0400, 1, 0, 1, 2, 0, 0);
    vecs[13] = mk("drain_rr", 2'b00, 32'h0, 0, 2'b00, 32'h0, 0, 1, 0,  0, 32'h0, 0, 1, 1, 1, 0, 0);
`else
    vecs[11] = mk("contend_fp", 2'b10, 32'h4000_0400, 1, 2'b10, 32'h4000_0500, 1, 1, 0,  1, 32'h4000_0400, 1, 1, 1, 1, 0, 0);
    vecs[12] = mk("loser_fp", 2'b00, 32'h0, 0, 2'b00, 32'h0, 0, 1, 0,  1, 32'h4000_0500, 1, 1, 0, 1, 0, 0);
    vecs[13] = mk("drain_fp", 2'b00, 32'h0, 0, 2'b00, 32'h0, 0, 1, 0,  0, 32'h0, 0, 1, 1, 2, 0, 0);
`endif

    drive_idle(1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Vector table: expected record queued when driven, popped mid-cycle when outputs settle.
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      drive_vec(vecs[i], i);
      exp_q.push_back(vecs[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      exp_wd = (e.e_ws == 1) ? D0 : (e.e_ws == 2) ? D1 : 32'h0;
      check({e.name, ".hsel"},   {31'b0, s_hsel}, {31'b0, e.e_sel});
      check({e.name, ".htrans"}, {30'b0, s_htrans}, e.e_sel ? 32'h2 : 32'h0);
      check({e.name, ".haddr"},  s_haddr, e.e_addr);
      check({e.name, ".hwrite"}, {31'b0, s_hwrite}, {31'b0, e.e_w});
      check({e.name, ".m0_hready"}, {31'b0, m0_hready}, {31'b0, e.e_h0});
      check({e.name, ".m1_hready"}, {31'b0, m1_hready}, {31'b0, e.e_h1});
      check({e.name, ".hwdata"}, s_hwdata, exp_wd);
      check({e.name, ".m0_hresp"}, {31'b0, m0_hresp}, {31'b0, e.e_r0});
      check({e.name, ".m1_hresp"}, {31'b0, m1_hresp}, {31'b0, e.e_r1});
      check({e.name, ".m0_hrdata"}, m0_hrdata, RD ^ i);
      check({e.name, ".m1_hrdata"}, m1_hrdata, RD ^ i);
      check({e.name, ".hburst"}, {29'b0, s_hburst}, 32'h0);
      check({e.name, ".hprot"},  {28'b0, s_hprot}, 32'h3);
      check({e.name, ".hready_in"}, {31'b0, s_hready_in}, {31'b0, e.rdy});
    end

    // Reset with a captured m1 request and an m0 data phase outstanding.
    @(posedge clk); #1;
    drive_idle(1'b1);
    m0_hsel = 1; m0_htrans = 2'b10; m0_haddr = 32'h4000_0104;
    @(posedge clk); #1;
    drive_idle(1'b0);
    m1_hsel = 1; m1_htrans = 2'b10; m1_haddr = 32'h4000_0600; m1_hwrite = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_reset.m1_hready", {31'b0, m1_hready}, 32'h0);
    check("pre_reset.m0_hready", {31'b0, m0_hready}, 32'h0);
    @(posedge clk); #1;
    drive_idle(1'b1);
    s_hresp = 1;
    rst_n = 1'b0;
    #1;
    check("in_reset.htrans", {30'b0, s_htrans}, 32'h0);
    check("in_reset.m0_hready", {31'b0, m0_hready}, 32'h1);
    check("in_reset.m1_hready", {31'b0, m1_hready}, 32'h1);
    check("in_reset.hwdata", s_hwdata, 32'h0);
    check("in_reset.m0_hresp", {31'b0, m0_hresp}, 32'h0);
    @(posedge clk); #1;
    check("reset_next.hsel", {31'b0, s_hsel}, 32'h0);
    check("reset_next.haddr", s_haddr, 32'h0);
    rst_n = 1'b1;
    s_hresp = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("no_replay.hsel", {31'b0, s_hsel}, 32'h0);
      check("no_replay.m1_hready", {31'b0, m1_hready}, 32'h1);
    end

    // Both masters stream four writes; expected grant order queued up front.
`ifdef APB_ARB_RR_EN
    for (int k = 0; k < 4; k++) begin
      grant_q.push_back('{addr: 32'h4000_1000 + 32'(4 * k), size: 3'b010});
      grant_q.push_back('{addr: 32'h4000_2000 + 32'(4 * k), size: 3'b001});
    end
`else
    for (int k = 0; k < 4; k++) grant_q.push_back('{addr: 32'h4000_1000 + 32'(4 * k), size: 3'b010});
    for (int k = 0; k < 4; k++) grant_q.push_back('{addr: 32'h4000_2000 + 32'(4 * k), size: 3'b001});
`endif
    idx0 = 0; idx1 = 0; acc0 = 0; acc1 = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (acc0) idx0++;
      if (acc1) idx1++;
      drive_idle(1'b1);
      if (idx0 < 4) begin
        m0_hsel = 1; m0_htrans = 2'b10; m0_hwrite = 1; m0_haddr = 32'h4000_1000 + 32'(4 * idx0);
      end
      if (idx1 < 4) begin
        m1_hsel = 1; m1_htrans = 2'b10; m1_hwrite = 1; m1_haddr = 32'h4000_2000 + 32'(4 * idx1);
      end
      @(negedge clk);
      if (s_hsel) begin
        if (grant_q.size() == 0) begin
          check("stream.extra_grant", s_haddr, 32'h0);
        end else begin
          grant_t g;
          g = grant_q.pop_front();
          check("stream.grant_addr", s_haddr, g.addr);
          check("stream.grant_size", {29'b0, s_hsize}, {29'b0, g.size});
          check("stream.grant_htrans", {30'b0, s_htrans}, 32'h2);
        end
      end
      acc0 = m0_hsel & m0_htrans[1] & m0_hready;
      acc1 = m1_hsel & m1_htrans[1] & m1_hready;
      if (grant_q.size() == 0 && idx0 + (acc0 ? 1 : 0) >= 4 && idx1 + (acc1 ? 1 : 0) >= 4) break;
    end
    check("stream.grants_outstanding", grant_q.size(), 32'h0);

    @(posedge clk); #1;
    drive_idle(1'b1);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
